// File: rtl/ysyx_25050147_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to instruction
// memory, hands each instruction to decode and accepts redirects from downstream.
module ysyx_25050147_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        rready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_drop;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_pc;
  logic [XLEN-1:0] r_fetch_cnt;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_drop_nxt;
  logic [XLEN-1:0] w_inst_nxt;
  logic [XLEN-1:0] w_inst_pc_nxt;
  logic            w_fault_nxt;
  logic [XLEN-1:0] w_fault_pc_nxt;
  logic [XLEN-1:0] w_fetch_cnt_nxt;
  logic            w_redir_bad;

  assign w_redir_bad = (redirect_pc[1:0] != 2'b00);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_inst      <= '0;
      r_inst_pc   <= '0;
      r_fault     <= 1'b0;
      r_fault_pc  <= '0;
      r_fetch_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop      <= w_drop_nxt;
      r_inst      <= w_inst_nxt;
      r_inst_pc   <= w_inst_pc_nxt;
      r_fault     <= w_fault_nxt;
      r_fault_pc  <= w_fault_pc_nxt;
      r_fetch_cnt <= w_fetch_cnt_nxt;
    end
  end

  // Next-state logic; a redirect outranks the normal progress of every active state
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_nxt      = r_drop;
    w_inst_nxt      = r_inst;
    w_inst_pc_nxt   = r_inst_pc;
    w_fault_nxt     = r_fault;
    w_fault_pc_nxt  = r_fault_pc;
    w_fetch_cnt_nxt = r_fetch_cnt;

    unique case (r_state)
      S_BOOT: w_state_nxt = S_REQ;

      S_REQ: begin
        if (redirect_valid) begin
          if (w_redir_bad) begin
            w_state_nxt    = S_HALT;
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt = redirect_pc;
            if (arready) begin
              w_drop_nxt  = 1'b1;
              w_state_nxt = S_WAIT;
            end
          end
        end else if (arready) begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          if (w_redir_bad) begin
            w_state_nxt    = S_HALT;
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt = redirect_pc;
            if (rvalid) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = S_REQ;
            end else begin
              w_drop_nxt = 1'b1;
            end
          end
        end else if (rvalid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else if (rresp != 2'b00) begin
            w_state_nxt    = S_HALT;
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = r_pc;
          end else begin
            w_inst_nxt    = rdata;
            w_inst_pc_nxt = r_pc;
            w_state_nxt   = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // A handshake is counted even when a redirect discards the instruction
        if (inst_ready) begin
          w_fetch_cnt_nxt = r_fetch_cnt + XLEN'(1);
        end
        if (redirect_valid) begin
          if (w_redir_bad) begin
            w_state_nxt    = S_HALT;
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = S_REQ;
          end
        end else if (inst_ready) begin
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = S_REQ;
        end
      end

      S_HALT: w_state_nxt = S_HALT;

      default: w_state_nxt = S_HALT;
    endcase
  end

  assign arvalid    = (r_state == S_REQ);
  assign rready     = (r_state == S_WAIT);
  assign inst_valid = (r_state == S_HOLD);
  assign araddr     = r_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fault      = r_fault;
  assign fault_pc   = r_fault_pc;
  assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_25050147_ifu.sv
// Bench for ysyx_25050147_ifu: directed scenarios plus a randomized run checked
// against an architectural PC / delivery-count model and a latency-randomized memory.
module tb_ysyx_25050147_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_25050147_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .arvalid        (arvalid),
    .araddr         (araddr),
    .arready        (arready),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .rresp          (rresp),
    .rready         (rready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed function of the address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic idle_inputs();
    arready        = 1'b0;
    rvalid         = 1'b0;
    rdata          = '0;
    rresp          = 2'b00;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valids got av=%b rr=%b iv=%b exp 0 0 0", arvalid, rready, inst_valid);
    end
    n_tests++;
    if (inst !== 32'h0 || inst_pc !== 32'h0 || fault !== 1'b0 || fault_pc !== 32'h0 || fetch_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs got inst=%h ipc=%h f=%b fpc=%h cnt=%h exp all zero",
               inst, inst_pc, fault, fault_pc, fetch_cnt);
    end
    n_tests++;
    if (araddr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_araddr got %h exp %h", araddr, RESET_PC);
    end
    rst = 1'b0;
    n_tests++;
    if (arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_arvalid got %b exp 0", arvalid);
    end
    @(negedge clk);
    n_tests++;
    if (arvalid !== 1'b1 || araddr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req got av=%b addr=%h exp 1 %h", arvalid, araddr, RESET_PC);
    end
  endtask

  task automatic test_basic();
    arready    = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wait got rr=%b av=%b exp 1 0", rready, arvalid);
    end
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h0000_0013;
    @(negedge clk);
    rvalid = 1'b0;
    n_tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL basic_inst got iv=%b inst=%h pc=%h exp 1 00000013 80000000", inst_valid, inst, inst_pc);
    end
    @(negedge clk);
    n_tests++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0004 || fetch_cnt !== 32'd1 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_next got av=%b addr=%h cnt=%0d iv=%b exp 1 80000004 1 0",
               arvalid, araddr, fetch_cnt, inst_valid);
    end
  endtask

  task automatic test_stall();
    arready    = 1'b1;
    inst_ready = 1'b0;
    @(negedge clk);
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h0010_0093;
    @(negedge clk);
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0004 ||
          arvalid !== 1'b0 || fetch_cnt !== 32'd1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got iv=%b inst=%h pc=%h av=%b cnt=%0d exp 1 00100093 80000004 0 1",
                 i, inst_valid, inst, inst_pc, arvalid, fetch_cnt);
      end
      @(negedge clk);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    n_tests++;
    if (fetch_cnt !== 32'd2 || arvalid !== 1'b1 || araddr !== 32'h8000_0008) begin
      n_fail++;
      $display("FAIL stall_release got cnt=%0d av=%b addr=%h exp 2 1 80000008", fetch_cnt, arvalid, araddr);
    end
  endtask

  task automatic test_redirect_wait();
    arready = 1'b1;
    @(negedge clk);
    arready        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_tests++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_wait_stay got rr=%b av=%b exp 1 0", rready, arvalid);
    end
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rvalid = 1'b0;
    n_tests++;
    if (inst_valid !== 1'b0 || arvalid !== 1'b1 || araddr !== 32'h8000_0100 || fetch_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL redir_wait_drop got iv=%b av=%b addr=%h cnt=%0d exp 0 1 80000100 2",
               inst_valid, arvalid, araddr, fetch_cnt);
    end
  endtask

  task automatic test_redirect_hold();
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h0000_0013;
    @(negedge clk);
    rvalid = 1'b0;
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL redir_hold_pre got iv=%b pc=%h exp 1 80000100", inst_valid, inst_pc);
    end
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    n_tests++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0200 || fetch_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL redir_hold got av=%b addr=%h cnt=%0d exp 1 80000200 3", arvalid, araddr, fetch_cnt);
    end
  endtask

  task automatic test_async_reset();
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    n_tests++;
    if (rready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre got rr=%b exp 1", rready);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
        inst_pc !== 32'h0 || fetch_cnt !== 32'h0 || araddr !== RESET_PC) begin
      n_fail++;
      $display("FAIL areset_imm got av=%b rr=%b iv=%b inst=%h ipc=%h cnt=%0d addr=%h exp 0 0 0 0 0 0 %h",
               arvalid, rready, inst_valid, inst, inst_pc, fetch_cnt, araddr, RESET_PC);
    end
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (arvalid !== 1'b0 || rready !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_boot got av=%b rr=%b exp 0 0", arvalid, rready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (arvalid !== 1'b1 || araddr !== RESET_PC || rready !== 1'b0 || inst_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL areset_req[%0d] got av=%b addr=%h rr=%b iv=%b exp 1 %h 0 0",
                 i, arvalid, araddr, rready, inst_valid, RESET_PC);
      end
    end
    rvalid = 1'b0;
  endtask

  task automatic test_fault_resp();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      arready    = 1'b1;
      inst_ready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = 32'(k);
      @(negedge clk);
      rvalid = 1'b0;
      @(negedge clk);
    end
    inst_ready = 1'b0;
    n_tests++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0008) begin
      n_fail++;
      $display("FAIL fault_setup got av=%b addr=%h exp 1 80000008", arvalid, araddr);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid  = 1'b1;
    rresp   = 2'd2;
    @(negedge clk);
    rvalid = 1'b0;
    rresp  = 2'd0;
    n_tests++;
    if (fault !== 1'b1 || fault_pc !== 32'h8000_0008 || inst_valid !== 1'b0 || fetch_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL fault_resp got f=%b fpc=%h iv=%b cnt=%0d exp 1 80000008 0 2",
               fault, fault_pc, inst_valid, fetch_cnt);
    end
    arready        = 1'b1;
    rvalid         = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 ||
          fault !== 1'b1 || fault_pc !== 32'h8000_0008) begin
        n_fail++;
        $display("FAIL halt_sticky[%0d] got av=%b rr=%b iv=%b f=%b fpc=%h exp 0 0 0 1 80000008",
                 i, arvalid, rready, inst_valid, fault, fault_pc);
      end
    end
    idle_inputs();
  endtask

  task automatic test_fault_redirect();
    do_reset();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0002;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_tests++;
    if (fault !== 1'b1 || fault_pc !== 32'h8000_0002 || arvalid !== 1'b0 || araddr !== RESET_PC) begin
      n_fail++;
      $display("FAIL fault_redirect got f=%b fpc=%h av=%b addr=%h exp 1 80000002 0 %h",
               fault, fault_pc, arvalid, araddr, RESET_PC);
    end
  endtask

  // Random traffic against an architectural model: the PC advances by 4 per delivered
  // instruction, jumps to any redirect target, and each delivered word must be memf(pc).
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] pend[$];
    int          delivered;
    logic        av, rr, iv;
    logic [31:0] addr_s;
    exp_pc    = RESET_PC;
    exp_cnt   = '0;
    delivered = 0;
    pend.delete();
    do_reset();
    @(negedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      arready        = ($urandom_range(0, 1) == 1);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF8;
      else redirect_pc = 32'h8000_0000 | (32'($urandom) & 32'h0000_FFFC);
      rvalid = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      rdata  = (pend.size() > 0) ? memf(pend[0]) : 32'($urandom);
      rresp  = 2'b00;
      av     = arvalid;
      rr     = rready;
      iv     = inst_valid;
      addr_s = araddr;

      if (av) begin
        n_tests++;
        if (addr_s !== exp_pc || pend.size() != 0) begin
          n_fail++;
          $display("FAIL rnd_req cyc=%0d got addr=%h outstanding=%0d exp %h 0", cyc, addr_s, pend.size(), exp_pc);
        end
      end
      if (rr && pend.size() != 1) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd_rready cyc=%0d got outstanding=%0d exp 1", cyc, pend.size());
      end
      if (iv) begin
        n_tests++;
        if (inst_pc !== exp_pc || inst !== memf(exp_pc)) begin
          n_fail++;
          $display("FAIL rnd_inst cyc=%0d got pc=%h inst=%h exp %h %h", cyc, inst_pc, inst, exp_pc, memf(exp_pc));
        end
      end
      n_tests++;
      if (fetch_cnt !== exp_cnt || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_cnt cyc=%0d got cnt=%0d fault=%b exp %0d 0", cyc, fetch_cnt, fault, exp_cnt);
      end

      if (av && arready) pend.push_back(addr_s);
      if (rvalid && rr) void'(pend.pop_front());
      if (iv && inst_ready) begin
        exp_cnt = exp_cnt + 32'd1;
        delivered++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      else if (iv && inst_ready) exp_pc = exp_pc + 32'd4;
      @(negedge clk);
    end
    idle_inputs();
    n_tests++;
    if (delivered < 100) begin
      n_fail++;
      $display("FAIL rnd_progress got %0d delivered exp >= 100", delivered);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_async_reset();
    test_fault_resp();
    test_fault_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
